// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, operation codes and the result flag bundle.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic neg;
        logic zero;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/addsub_serial_if.sv
// Request/result bundle between the ALU control and the bit-serial adder/subtractor.
interface addsub_serial_if #(parameter int WIDTH = 3);
    // init is taken only while busy=0 (IDLE or DONE); operands and op/sgn are latched
    // on that edge. busy stays high for WIDTH+1 cycles, then done pulses for one cycle
    // with sal/neg/zero/ovf valid; those outputs hold until the next done or reset.
    logic             init;
    logic             op;
    logic             sgn;
    logic [WIDTH-1:0] xi;
    logic [WIDTH-1:0] yi;
    logic [WIDTH:0]   sal;
    logic             busy;
    logic             done;
    logic             neg;
    logic             zero;
    logic             ovf;

    modport master (
        output init, op, sgn, xi, yi,
        input  sal, busy, done, neg, zero, ovf
    );

    modport slave (
        input  init, op, sgn, xi, yi,
        output sal, busy, done, neg, zero, ovf
    );

endinterface

// File: rtl/full_adder_1b.sv
// Single-bit full adder used as the arithmetic core of the serial loop.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_serial.sv
// Bit-serial add/subtract of two WIDTH-bit operands, producing an exact WIDTH+1-bit
// result LSB first plus neg/zero/ovf flags.
module addsub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    addsub_serial_if.slave     bus,
    output state_t             fsm_state
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH:0]   a_sr;
    logic [WIDTH:0]   b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH:0]   r_nx;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             sum;
    logic             cout;
    logic             op_q;
    logic             sgn_q;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   sal_q;
    flags_t           flags_q;
    flags_t           flags_nx;

    full_adder_1b u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (sum),
        .cout (cout)
    );

    always_comb begin
        a_ext  = bus.sgn ? {bus.xi[WIDTH-1], bus.xi} : {1'b0, bus.xi};
        b_ext  = bus.sgn ? {bus.yi[WIDTH-1], bus.yi} : {1'b0, bus.yi};
        accept = bus.init && ((state == ST_IDLE) || (state == ST_DONE));
        last   = (state == ST_RUN) && (cnt == CNT_W'(WIDTH));
        // The final sum bit is merged here so sal can load on the same edge it is produced.
        r_nx   = {sum, r_sr};
    end

    always_comb begin
        flags_nx.neg  = r_nx[WIDTH] & (sgn_q | op_q);
        flags_nx.zero = (r_nx == '0);
        flags_nx.ovf  = sgn_q ? (r_nx[WIDTH] ^ r_nx[WIDTH-1]) : r_nx[WIDTH];
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN:  if (last) state_nx = ST_DONE;
            ST_DONE: state_nx = accept ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            r_sr    <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            op_q    <= OP_ADD;
            sgn_q   <= 1'b0;
            sal_q   <= '0;
            flags_q <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            a_sr  <= a_ext;
            b_sr  <= (bus.op == OP_SUB) ? ~b_ext : b_ext;
            carry <= bus.op;
            cnt   <= '0;
            op_q  <= bus.op;
            sgn_q <= bus.sgn;
        end else if (state == ST_RUN) begin
            a_sr  <= {1'b0, a_sr[WIDTH:1]};
            b_sr  <= {1'b0, b_sr[WIDTH:1]};
            r_sr  <= r_nx[WIDTH:1];
            carry <= cout;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sal_q   <= r_nx;
                flags_q <= flags_nx;
            end
        end
    end

    assign bus.sal   = sal_q;
    assign bus.neg   = flags_q.neg;
    assign bus.zero  = flags_q.zero;
    assign bus.ovf   = flags_q.ovf;
    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial at WIDTH=3 and WIDTH=8 with hand-computed vectors.
module tb_addsub_serial;
    import alu_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    state_t st3;
    state_t st8;
    int     vectors = 0;
    int     miscompares = 0;

    addsub_serial_if #(.WIDTH(3)) bus3 ();
    addsub_serial_if #(.WIDTH(8)) bus8 ();

    addsub_serial #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .fsm_state(st3));
    addsub_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .fsm_state(st8));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run3(input string tag, input logic op, input logic sgn,
                        input logic [2:0] x, input logic [2:0] y, input logic [3:0] e_sal,
                        input logic e_neg, input logic e_zero, input logic e_ovf);
        bus3.op = op; bus3.sgn = sgn; bus3.xi = x; bus3.yi = y; bus3.init = 1'b1;
        step();
        bus3.init = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus3.xi = 3'($urandom_range(0, 7));
            bus3.yi = 3'($urandom_range(0, 7));
            bus3.op = 1'($urandom_range(0, 1));
            check({tag, ".busy"}, 32'(bus3.busy), 32'd1);
            check({tag, ".nodone"}, 32'(bus3.done), 32'd0);
            step();
        end
        check({tag, ".done"}, 32'(bus3.done), 32'd1);
        check({tag, ".busy_low"}, 32'(bus3.busy), 32'd0);
        check({tag, ".sal"}, 32'(bus3.sal), 32'(e_sal));
        check({tag, ".neg"}, 32'(bus3.neg), 32'(e_neg));
        check({tag, ".zero"}, 32'(bus3.zero), 32'(e_zero));
        check({tag, ".ovf"}, 32'(bus3.ovf), 32'(e_ovf));
        step();
        check({tag, ".done_pulse"}, 32'(bus3.done), 32'd0);
        check({tag, ".sal_hold"}, 32'(bus3.sal), 32'(e_sal));
    endtask

    task automatic model8(input logic op, input logic sgn, input logic [7:0] x,
                          input logic [7:0] y, output logic [8:0] r, output logic neg,
                          output logic zero, output logic ovf);
        int a;
        int b;
        int res;
        a   = sgn ? int'($signed(x)) : int'(x);
        b   = sgn ? int'($signed(y)) : int'(y);
        res = op ? a - b : a + b;
        r    = res[8:0];
        neg  = (res < 0);
        zero = (res == 0);
        ovf  = sgn ? ((res < -128) || (res > 127)) : ((res < 0) || (res > 255));
    endtask

    task automatic run8(input logic op, input logic sgn, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] e_r;
        logic       e_n;
        logic       e_z;
        logic       e_o;
        int         n;
        model8(op, sgn, x, y, e_r, e_n, e_z, e_o);
        bus8.op = op; bus8.sgn = sgn; bus8.xi = x; bus8.yi = y; bus8.init = 1'b1;
        step();
        bus8.init = 1'b0;
        bus8.xi = ~x;
        n = 1;
        while (!bus8.done && n < 20) begin
            step();
            n++;
        end
        check("w8.latency", 32'(n), 32'd10);
        check("w8.sal", 32'(bus8.sal), 32'(e_r));
        check("w8.flags", 32'({bus8.neg, bus8.zero, bus8.ovf}), 32'({e_n, e_z, e_o}));
        step();
    endtask

    initial begin
        logic [7:0] vals [8];
        vals = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd129, 8'd254, 8'd255};
        rst = 1'b1;
        bus3.init = 1'b0; bus3.op = 1'b0; bus3.sgn = 1'b0; bus3.xi = '0; bus3.yi = '0;
        bus8.init = 1'b0; bus8.op = 1'b0; bus8.sgn = 1'b0; bus8.xi = '0; bus8.yi = '0;
        step();
        step();
        check("rst.state", 32'(st3), 32'(ST_IDLE));
        check("rst.outs", 32'({bus3.sal, bus3.busy, bus3.done, bus3.neg, bus3.zero, bus3.ovf}), 32'd0);
        rst = 1'b0;
        step();

        run3("t1_5m3", 1'b1, 1'b0, 3'd5, 3'd3, 4'b0010, 1'b0, 1'b0, 1'b0);
        run3("t2_3m5", 1'b1, 1'b0, 3'd3, 3'd5, 4'b1110, 1'b1, 1'b0, 1'b1);
        run3("t3_s3mm3", 1'b1, 1'b1, 3'b011, 3'b101, 4'b0110, 1'b0, 1'b0, 1'b1);
        run3("e_s4m4", 1'b1, 1'b1, 3'b100, 3'b100, 4'b0000, 1'b0, 1'b1, 1'b0);
        run3("e_0m7", 1'b1, 1'b0, 3'd0, 3'd7, 4'b1001, 1'b1, 1'b0, 1'b1);
        run3("s_3p3", 1'b0, 1'b1, 3'd3, 3'd3, 4'b0110, 1'b0, 1'b0, 1'b1);
        run3("s_m4pm1", 1'b0, 1'b1, 3'd4, 3'd7, 4'b1011, 1'b1, 1'b0, 1'b1);
        run3("t3b_7p7", 1'b0, 1'b0, 3'd7, 3'd7, 4'b1110, 1'b0, 1'b0, 1'b1);

        // Abort mid-run: outputs from the previous 7+7 must be cleared, no done follows.
        bus3.op = 1'b0; bus3.sgn = 1'b0; bus3.xi = 3'd1; bus3.yi = 3'd1; bus3.init = 1'b1;
        step();
        bus3.init = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5.state", 32'(st3), 32'(ST_IDLE));
        check("t5.outs", 32'({bus3.sal, bus3.busy, bus3.done, bus3.neg, bus3.zero, bus3.ovf}), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check("t5.no_done", 32'(bus3.done), 32'd0);
            step();
        end
        run3("t5_after", 1'b1, 1'b0, 3'd5, 3'd3, 4'b0010, 1'b0, 1'b0, 1'b0);

        // Back-to-back with init held high; operands differ except at the DONE edges.
        bus3.op = 1'b1; bus3.sgn = 1'b0; bus3.xi = 3'd4; bus3.yi = 3'd4; bus3.init = 1'b1;
        step();
        for (int i = 1; i <= 15; i++) begin
            check("t4.done", 32'(bus3.done), 32'((i % 5) == 0));
            check("t4.busy", 32'(bus3.busy), 32'((i % 5) != 0));
            if ((i % 5) == 0) begin
                check("t4.result", 32'({bus3.sal, bus3.zero, bus3.neg, bus3.ovf}), 32'b0000_1_0_0);
                bus3.xi = 3'd4;
                bus3.yi = 3'd4;
                if (i == 15) bus3.init = 1'b0;
            end else begin
                bus3.xi = 3'd6;
                bus3.yi = 3'd1;
            end
            step();
        end
        check("t4.idle", 32'({bus3.busy, bus3.done}), 32'd0);

        foreach (vals[i]) begin
            foreach (vals[j]) begin
                for (int m = 0; m < 4; m++) run8(m[0], m[1], vals[i], vals[j]);
            end
        end
        for (int k = 0; k < 32; k++) begin
            run8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
